// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single variable-latency memory port.
// Tie-break is fixed data-first unless ARB_ROUND_ROBIN_EN is defined (then alternating).
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          stallF,
    output logic          stallM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t        r_state;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          r_if_ready;
    logic          r_dm_ready;
    logic          r_err;
    logic [7:0]    r_wait;

    state_t        w_state_nxt;
    logic          w_mem_req_nxt;
    logic          w_mem_we_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_mem_wdata_nxt;
    logic [DW-1:0] w_if_rdata_nxt;
    logic [DW-1:0] w_dm_rdata_nxt;
    logic          w_if_ready_nxt;
    logic          w_dm_ready_nxt;
    logic          w_err_nxt;
    logic [7:0]    w_wait_nxt;

    logic          w_if_elig;
    logic          w_dm_elig;
    logic          w_tie_dm;
    logic          w_grant_dm;
    logic          w_grant_if;
    logic          w_timeout;

    // A port whose ready is high still shows the req of the access just finished.
    assign w_if_elig = if_req & ~r_if_ready;
    assign w_dm_elig = dm_req & ~r_dm_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dm;
    logic w_last_dm_nxt;

    assign w_tie_dm = ~r_last_dm;

    always_comb begin
        w_last_dm_nxt = r_last_dm;
        if (r_state == IDLE) begin
            if (w_grant_dm) begin
                w_last_dm_nxt = 1'b1;
            end else if (w_grant_if) begin
                w_last_dm_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_dm <= 1'b0;
        end else begin
            r_last_dm <= w_last_dm_nxt;
        end
    end
`else
    assign w_tie_dm = 1'b1;
`endif

    assign w_grant_dm = w_dm_elig & (~w_if_elig | w_tie_dm);
    assign w_grant_if = w_if_elig & ~w_grant_dm;
    assign w_timeout  = (r_wait == LP_MAX_WAIT);

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_ready_nxt  = 1'b0;
        w_dm_ready_nxt  = 1'b0;
        w_err_nxt       = 1'b0;
        w_wait_nxt      = r_wait;

        case (r_state)
            IDLE: begin
                if (w_grant_dm) begin
                    w_state_nxt     = DM_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                    w_wait_nxt      = 8'd0;
                end else if (w_grant_if) begin
                    w_state_nxt    = IF_BUSY;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = if_addr;
                    w_wait_nxt     = 8'd0;
                end
            end

            IF_BUSY: begin
                // A late ack in the final wait cycle still counts as a normal completion.
                if (mem_ack) begin
                    w_state_nxt    = IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_if_ready_nxt = 1'b1;
                    w_if_rdata_nxt = mem_rdata;
                end else if (w_timeout) begin
                    w_state_nxt    = IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_if_ready_nxt = 1'b1;
                    w_err_nxt      = 1'b1;
                    w_if_rdata_nxt = '0;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end

            DM_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt    = IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_dm_ready_nxt = 1'b1;
                    w_dm_rdata_nxt = r_mem_we ? r_dm_rdata : mem_rdata;
                end else if (w_timeout) begin
                    w_state_nxt    = IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_dm_ready_nxt = 1'b1;
                    w_err_nxt      = 1'b1;
                    w_dm_rdata_nxt = '0;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
                w_mem_we_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_err       <= 1'b0;
            r_wait      <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_dm_ready  <= w_dm_ready_nxt;
            r_err       <= w_err_nxt;
            r_wait      <= w_wait_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign err       = r_err;
    assign stallF    = if_req & ~r_if_ready;
    assign stallM    = dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single accesses plus hand-written
// sequences for timeout, reset during an access and two-port arbitration order.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          stallF;
    logic          stallM;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] seq_exp[4];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stallF(stallF), .stallM(stallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access on one port; memory acks ack_lat cycles after mem_req is first seen.
    task automatic run_vec(input vec_t v);
        int cyc;
        bit stable_ok;
        @(negedge clk);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        check("stall_on_req", v.is_dm ? stallM : stallF, 1);
        cyc = 0;
        while (!mem_req && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        check("grant_latency", cyc, 1);
        check("mem_addr", mem_addr, v.addr);
        check("mem_we", mem_we, v.is_dm ? v.we : 1'b0);
        if (v.is_dm && v.we) check("mem_wdata", mem_wdata, v.wdata);
        stable_ok = 1'b1;
        for (int k = 0; k < v.ack_lat; k++) begin
            @(negedge clk);
            if (!mem_req || mem_addr !== v.addr || if_ready || dm_ready) stable_ok = 1'b0;
        end
        check("busy_stable", stable_ok, 1);
        mem_ack = 1'b1;
        mem_rdata = v.rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        check("ready", v.is_dm ? dm_ready : if_ready, 1);
        check("other_ready", v.is_dm ? if_ready : dm_ready, 0);
        check("err_clear", err, 0);
        check("mem_req_drop", mem_req, 0);
        check("rdata", v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
        check("stall_in_ready", v.is_dm ? stallM : stallF, 0);
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    // Both ports request together; memory acks every request immediately.
    task automatic run_pair(input int per_port);
        int n_grant;
        int n_if;
        int n_dm;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        n_grant = 0; n_if = 0; n_dm = 0;
        for (int c = 0; c < 40 && (if_req || dm_req); c++) begin
            @(negedge clk);
            if (if_ready) begin
                n_if++;
                check("pair_if_rdata", if_rdata, 32'h1100);
                if (n_if == per_port) if_req = 1'b0;
            end
            if (dm_ready) begin
                n_dm++;
                check("pair_dm_rdata", dm_rdata, 32'h1200);
                if (n_dm == per_port) dm_req = 1'b0;
            end
            if (mem_req) begin
                if (n_grant < 4) check("grant_order", mem_addr, seq_exp[n_grant]);
                n_grant++;
                mem_ack = 1'b1;
                mem_rdata = mem_addr + 32'h1000;
            end else begin
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0;
        check("pair_grants", n_grant, 2 * per_port);
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'hE281_1001, 1,  32'hE281_1001};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_0007, 32'hCAFE_F00D, 1,  32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,          32'hDEAD_BEEF, 3,  32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0088, 32'h1234_5678, 32'h0BAD_F00D, 2,  32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,          32'h00A0_0093, 5,  32'h00A0_0093};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFF, 1,  32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h55AA_55AA, 15, 32'h55AA_55AA};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_02C0, 32'h0000_00A5, 32'h7777_7777, 1,  32'h0000_1200};

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_readys", {if_ready, dm_ready}, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        // Stray ack while idle must do nothing.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_ready", {if_ready, dm_ready, err}, 0);
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_rdata", if_rdata, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Data read that is never acked: ready+err 16 cycles after the grant edge.
        begin
            bit busy_ok;
            @(negedge clk);
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
            busy_ok = 1'b1;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                if (!mem_req || dm_ready || err) busy_ok = 1'b0;
            end
            check("to_busy_hold", busy_ok, 1);
            @(negedge clk);
            check("to_dm_ready", dm_ready, 1);
            check("to_err", err, 1);
            check("to_dm_rdata", dm_rdata, 0);
            check("to_mem_req", mem_req, 0);
            dm_req = 1'b0;
            @(negedge clk);
            check("to_err_pulse", {err, dm_ready}, 0);
            check("to_idle", mem_req, 0);
        end

        // Reset lands mid fetch with an ack in flight; fetch must be re-granted after.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk);
        check("rb_granted", mem_req, 1);
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        #1;
        check("rb_req_async", mem_req, 0);
        @(negedge clk);
        check("rb_no_ready", {if_ready, err}, 0);
        check("rb_if_rdata", if_rdata, 0);
        reset = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("rb_regrant", mem_req, 1);
        check("rb_regrant_addr", mem_addr, 32'h300);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rb_if_ready", if_ready, 1);
        check("rb_if_rdata_new", if_rdata, 32'h2222_2222);
        if_req = 1'b0;

        // Simultaneous requests held for two accesses each (last grant was fetch).
        seq_exp[0] = 32'h200; seq_exp[1] = 32'h100;
        seq_exp[2] = 32'h200; seq_exp[3] = 32'h100;
        run_pair(2);

        // After a data grant, a fresh tie separates the two tie-break policies.
        run_vec(vecs[7]);
`ifdef ARB_ROUND_ROBIN_EN
        seq_exp[0] = 32'h100; seq_exp[1] = 32'h200;
`else
        seq_exp[0] = 32'h200; seq_exp[1] = 32'h100;
`endif
        run_pair(1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
